// File: rtl/dmem_copy_engine.sv
// Word-block copy engine: reads len words from src_addr and writes them to dst_addr, one word per two cycles.
// Optional XOR checksum of transferred words is built when DMEM_COPY_CKSUM_EN is defined.
module dmem_copy_engine #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_count;
  logic [DW-1:0] r_data_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Outputs decode only from registered state and pointers; start feeds next state alone.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next   = r_state;
    busy     = 1'b0;
    done     = 1'b0;
    mem_wen  = 1'b0;
    mem_addr = '0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = (len == '0) ? S_DONE : S_READ;
      end
      S_READ: begin
        busy     = 1'b1;
        mem_addr = r_rd_ptr;
        w_next   = S_WRITE;
      end
      S_WRITE: begin
        busy     = 1'b1;
        mem_wen  = 1'b1;
        mem_addr = r_wr_ptr;
        w_next   = (r_count == AW'(1)) ? S_DONE : S_READ;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_data_q <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && (len != '0)) begin
            r_rd_ptr <= src_addr;
            r_wr_ptr <= dst_addr;
            r_count  <= len;
          end
        end
        S_READ:  r_data_q <= mem_rdata;
        S_WRITE: begin
          // Pointers wrap silently modulo 2^AW.
          r_rd_ptr <= r_rd_ptr + AW'(1);
          r_wr_ptr <= r_wr_ptr + AW'(1);
          r_count  <= r_count - AW'(1);
        end
        default: ;
      endcase
    end
  end

  assign mem_wdata = r_data_q;

`ifdef DMEM_COPY_CKSUM_EN
  logic [DW-1:0] r_cksum_q;

  // Cleared on any accepted start (including len=0), held after done until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cksum_q <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_cksum_q <= '0;
    end else if (r_state == S_WRITE) begin
      r_cksum_q <= r_cksum_q ^ r_data_q;
    end
  end

  assign checksum = r_cksum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Self-checking bench for dmem_copy_engine: behavioural memory, array-level copy model, cycle timing checks.
module tb_dmem_copy_engine;

  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [AW-1:0] len;
  logic          busy;
  logic          done;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] checksum;

  logic [DW-1:0] tb_mem  [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] last_ck;
  int n_tests;
  int n_fail;

  dmem_copy_engine #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .checksum  (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = tb_mem[mem_addr];
  always @(posedge clk) if (mem_wen) tb_mem[mem_addr] = mem_wdata;

  task automatic set_word(input int a, input logic [DW-1:0] v);
    tb_mem[a]  = v;
    ref_mem[a] = v;
  endtask

  task automatic compare_mem(input string name);
    int bad;
    int first;
    bad   = 0;
    first = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (tb_mem[i] !== ref_mem[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL %s: %0d words differ, first at %0d got %h want %h", name, bad, first,
               tb_mem[first], ref_mem[first]);
    end
  endtask

  task automatic check_outputs_reset(input string name);
    n_tests++;
    if ({busy, done, mem_wen, mem_addr, mem_wdata, checksum} !== '0) begin
      n_fail++;
      $display("FAIL %s: busy=%b done=%b wen=%b addr=%0d wdata=%h cksum=%h want all zero", name,
               busy, done, mem_wen, mem_addr, mem_wdata, checksum);
    end
  endtask

  // Runs one command and checks every cycle against the timing rules, then memory and checksum.
  task automatic run_copy(input string name, input int src, input int dst, input int ln,
                          input bit poke_busy);
    logic [DW-1:0] exp_ck;
    logic [11:0]   obs;
    logic [11:0]   exp;
    logic          e_busy;
    logic          e_done;
    logic          e_wen;
    logic [AW-1:0] e_addr;
    exp_ck = '0;
    for (int k = 0; k < ln; k++) begin
      ref_mem[(dst + k) % DEPTH] = ref_mem[(src + k) % DEPTH];
      exp_ck ^= ref_mem[(dst + k) % DEPTH];
    end
`ifndef DMEM_COPY_CKSUM_EN
    exp_ck = '0;
`endif
    @(negedge clk);
    start    = 1'b1;
    src_addr = AW'(src);
    dst_addr = AW'(dst);
    len      = AW'(ln);
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    src_addr = AW'($urandom);
    dst_addr = AW'($urandom);
    len      = AW'($urandom);
    for (int c = 1; c <= 2 * ln + 1; c++) begin
      if (c > 1) @(negedge clk);
      e_busy = (c <= 2 * ln);
      e_done = (c == 2 * ln + 1);
      e_wen  = e_busy && (c % 2 == 0);
      if (!e_busy)    e_addr = '0;
      else if (c % 2) e_addr = AW'((src + (c - 1) / 2) % DEPTH);
      else            e_addr = AW'((dst + c / 2 - 1) % DEPTH);
      obs = {busy, done, mem_wen, mem_addr};
      exp = {e_busy, e_done, e_wen, e_addr};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s cycle %0d: busy/done/wen/addr got %b/%b/%b/%0d want %b/%b/%b/%0d", name, c,
                 busy, done, mem_wen, mem_addr, e_busy, e_done, e_wen, e_addr);
      end
      if (e_done) begin
        n_tests++;
        if (checksum !== exp_ck) begin
          n_fail++;
          $display("FAIL %s checksum: got %h want %h", name, checksum, exp_ck);
        end
      end
      start = poke_busy && (c == 3 || c == 5);
    end
    start   = 1'b0;
    last_ck = exp_ck;
    compare_mem(name);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    len = '0;
    for (int i = 0; i < DEPTH; i++) set_word(i, $urandom);
    repeat (2) @(negedge clk);
    check_outputs_reset("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs_reset("idle_after_reset");
  endtask

  task automatic test_basic;
    logic [DW-1:0] v [4];
    logic [DW-1:0] exp_ck;
    v = '{32'h3243f6a8, 32'h885a308d, 32'h313198a2, 32'he0370734};
    for (int i = 0; i < 4; i++) set_word(i, v[i]);
    run_copy("basic", 0, 100, 4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (tb_mem[100 + i] !== v[i]) begin
        n_fail++;
        $display("FAIL basic word %0d: got %h want %h", 100 + i, tb_mem[100 + i], v[i]);
      end
    end
`ifdef DMEM_COPY_CKSUM_EN
    exp_ck = 32'h6b1f59b3;
`else
    exp_ck = 32'h0;
`endif
    @(negedge clk);
    n_tests++;
    if (checksum !== exp_ck) begin
      n_fail++;
      $display("FAIL basic checksum_hold: got %h want %h", checksum, exp_ck);
    end
  endtask

  task automatic test_zero_len;
    run_copy("zero_len", 37, 250, 0, 1'b0);
  endtask

  task automatic test_wrap;
    run_copy("wrap_src", 510, 200, 4, 1'b0);
    run_copy("wrap_dst", 300, 510, 4, 1'b0);
  endtask

  task automatic test_start_while_busy;
    run_copy("start_busy", 20, 60, 4, 1'b1);
  endtask

  task automatic test_overlap;
    logic [DW-1:0] a;
    a = 32'haaaa0001;
    set_word(0, a);
    set_word(1, 32'hbbbb0002);
    set_word(2, 32'hcccc0003);
    set_word(3, 32'hdddd0004);
    run_copy("overlap", 0, 1, 3, 1'b0);
    for (int i = 1; i < 4; i++) begin
      n_tests++;
      if (tb_mem[i] !== a) begin
        n_fail++;
        $display("FAIL overlap word %0d: got %h want %h", i, tb_mem[i], a);
      end
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    start    = 1'b1;
    src_addr = AW'(40);
    dst_addr = AW'(140);
    len      = AW'(4);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (mem_wen !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid pre_wen: got %b want 1", mem_wen);
    end
    rst_n = 1'b0;
    #1;
    check_outputs_reset("reset_mid_async");
    ref_mem[140] = ref_mem[40];
    @(negedge clk);
    rst_n = 1'b1;
    compare_mem("reset_mid_mem");
    run_copy("after_reset", 40, 140, 4, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_copy("b2b_a", 5, 405, 3, 1'b0);
    run_copy("b2b_b", 405, 9, 3, 1'b0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 32; i++) set_word($urandom_range(DEPTH - 1), $urandom);
      run_copy($sformatf("random%0d", n), $urandom_range(DEPTH - 1), $urandom_range(DEPTH - 1),
               (n == 4) ? 0 : $urandom_range(24, 1), n[0]);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
    test_start_while_busy();
    test_overlap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
